// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle LEGv8 control unit (FETCH/DECODE/EXEC/MEM/WB) with
//            memory ready handshake, MEM timeout fault and registered immediate.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
  parameter int DATA_W      = 64,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  input  logic              mem_ready,
  input  logic              zero,
  input  logic              flag_n,
  input  logic              flag_v,
  output logic              fetch_req,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              reg2loc,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              set_flag,
  output logic              link,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] imm,
  output logic              retire,
  output logic              illegal,
  output logic              mem_fault,
  output logic [CNT_W-1:0]  retired,
  output logic [2:0]        state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [3:0] K_NONE = 4'd0;
  localparam logic [3:0] K_B    = 4'd1;
  localparam logic [3:0] K_BL   = 4'd2;
  localparam logic [3:0] K_ADDI = 4'd3;
  localparam logic [3:0] K_ADDS = 4'd4;
  localparam logic [3:0] K_SUBS = 4'd5;
  localparam logic [3:0] K_BLT  = 4'd6;
  localparam logic [3:0] K_CBZ  = 4'd7;
  localparam logic [3:0] K_BR   = 4'd8;
  localparam logic [3:0] K_LDUR = 4'd9;
  localparam logic [3:0] K_STUR = 4'd10;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [31:0]       ir_word;
  logic [3:0]        cls;
  logic [3:0]        dec_class;
  logic [DATA_W-1:0] dec_imm;
  logic [7:0]        wait_cnt;
  logic [2:0]        next_state;

  always_comb begin
    dec_class = K_NONE;
    if (ir_word[31:26] == 6'b000101)                            dec_class = K_B;
    else if (ir_word[31:26] == 6'b100101)                       dec_class = K_BL;
    else if (ir_word[31:22] == 10'b1001000100)                  dec_class = K_ADDI;
    else if (ir_word[31:21] == 11'b10101011000)                 dec_class = K_ADDS;
    else if (ir_word[31:21] == 11'b11101011000)                 dec_class = K_SUBS;
    else if (ir_word[31:24] == 8'h54 && ir_word[4:0] == 5'h0B)  dec_class = K_BLT;
    else if (ir_word[31:24] == 8'hB4)                           dec_class = K_CBZ;
    else if (ir_word[31:21] == 11'b11010110000)                 dec_class = K_BR;
    else if (ir_word[31:21] == 11'b11111000010)                 dec_class = K_LDUR;
    else if (ir_word[31:21] == 11'b11111000000)                 dec_class = K_STUR;
  end

  always_comb begin
    dec_imm = '0;
    case (dec_class)
      K_B, K_BL:     dec_imm = {{(DATA_W-26){ir_word[25]}}, ir_word[25:0]};
      K_BLT, K_CBZ:  dec_imm = {{(DATA_W-19){ir_word[23]}}, ir_word[23:5]};
      K_ADDI:        dec_imm = {{(DATA_W-12){1'b0}}, ir_word[21:10]};
      K_LDUR, K_STUR: dec_imm = {{(DATA_W-9){ir_word[20]}}, ir_word[20:12]};
      default:       dec_imm = '0;
    endcase
  end

  always_comb begin
    next_state = state;
    fetch_req  = (state == S_FETCH);
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    set_flag   = 1'b0;
    link       = 1'b0;
    alu_op     = 3'b000;
    retire     = 1'b0;
    illegal    = 1'b0;
    mem_fault  = 1'b0;
    case (state)
      S_FETCH: begin
        if (instr_valid) begin
          ir_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_class == K_NONE) begin
          illegal    = 1'b1;
          pc_write   = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          K_ADDI: begin
            alu_src    = 1'b1;
            alu_op     = 3'b010;
            next_state = S_WB;
          end
          K_ADDS: begin
            alu_op     = 3'b010;
            set_flag   = 1'b1;
            next_state = S_WB;
          end
          K_SUBS: begin
            alu_op     = 3'b011;
            set_flag   = 1'b1;
            next_state = S_WB;
          end
          K_LDUR, K_STUR: begin
            alu_src    = 1'b1;
            alu_op     = 3'b010;
            reg2loc    = (cls == K_STUR);
            next_state = S_MEM;
          end
          K_B, K_BL: begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            reg_write  = (cls == K_BL);
            link       = (cls == K_BL);
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          K_CBZ: begin
            reg2loc    = 1'b1;
            pc_write   = 1'b1;
            pc_src     = zero ? 2'b01 : 2'b00;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          K_BLT: begin
            pc_write   = 1'b1;
            pc_src     = (flag_n != flag_v) ? 2'b01 : 2'b00;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          K_BR: begin
            reg2loc    = 1'b1;
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        alu_src   = 1'b1;
        alu_op    = 3'b010;
        reg2loc   = (cls == K_STUR);
        mem_read  = (cls == K_LDUR);
        mem_write = (cls == K_STUR);
        // A ready arriving on the timeout cycle still completes the access.
        if (mem_ready) begin
          if (cls == K_LDUR) begin
            next_state = S_WB;
          end else begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        end else if (wait_cnt == TIMEOUT_CNT) begin
          mem_fault  = 1'b1;
          pc_write   = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (cls == K_LDUR);
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    if (reset) begin
      next_state = S_FETCH;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      set_flag   = 1'b0;
      link       = 1'b0;
      alu_op     = 3'b000;
      retire     = 1'b0;
      illegal    = 1'b0;
      mem_fault  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      ir_word  <= '0;
      cls      <= K_NONE;
      imm      <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && instr_valid) ir_word <= instruction;
      if (state == S_DECODE) begin
        cls <= dec_class;
        imm <= dec_imm;
      end
      if (state == S_EXEC)                    wait_cnt <= '0;
      else if (state == S_MEM && !mem_ready)  wait_cnt <= wait_cnt + 8'd1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// Scoreboard bench for multicycle_control: directed instructions, expected
// EXEC controls and end-of-instruction records are queued and checked by a monitor.
module tb_multicycle_control;
  localparam int DATA_W      = 64;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 32;

  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] instruction = '0;
  logic instr_valid = 1'b0, mem_ready = 1'b0, zero = 1'b0, flag_n = 1'b0, flag_v = 1'b0;
  logic fetch_req, ir_write, pc_write, reg2loc, alu_src, mem_to_reg, reg_write;
  logic mem_read, mem_write, set_flag, link, retire, illegal, mem_fault;
  logic [1:0] pc_src;
  logic [2:0] alu_op, state;
  logic [DATA_W-1:0] imm;
  logic [CNT_W-1:0] retired;

  multicycle_control #(.DATA_W(DATA_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .zero(zero), .flag_n(flag_n), .flag_v(flag_v),
    .fetch_req(fetch_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg2loc(reg2loc), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .set_flag(set_flag), .link(link),
    .alu_op(alu_op), .imm(imm), .retire(retire), .illegal(illegal), .mem_fault(mem_fault),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       alu_src;
    logic [2:0] alu_op;
    logic       reg2loc, set_flag, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, link, retire;
  } exec_t;

  typedef struct {
    logic [63:0] trace;
    int          lat, nmem;
    logic [1:0]  pc_src;
    logic        reg_write, mem_to_reg, retire, illegal, mem_fault;
    logic [63:0] imm;
    logic [31:0] ret;
  } end_t;

  int checks = 0;
  int failures = 0;
  exec_t exec_q[$];
  end_t  end_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exec_t mk_ex(input logic as, input logic [2:0] op, input logic r2l,
                                  input logic sf, input logic pw, input logic [1:0] ps,
                                  input logic rw, input logic lk, input logic rt);
    exec_t e;
    e.alu_src = as; e.alu_op = op; e.reg2loc = r2l; e.set_flag = sf; e.pc_write = pw;
    e.pc_src = ps; e.reg_write = rw; e.link = lk; e.retire = rt;
    return e;
  endfunction

  function automatic end_t mk_end(input logic [63:0] tr, input int lat, input int nm,
                                  input logic [1:0] ps, input logic rw, input logic m2r,
                                  input logic rt, input logic il, input logic mf,
                                  input logic [63:0] im, input logic [31:0] ret);
    end_t e;
    e.trace = tr; e.lat = lat; e.nmem = nm; e.pc_src = ps; e.reg_write = rw;
    e.mem_to_reg = m2r; e.retire = rt; e.illegal = il; e.mem_fault = mf; e.imm = im; e.ret = ret;
    return e;
  endfunction

  // State trace as octal digits: FETCH, DECODE, EXEC, nm MEM cycles, optional WB.
  function automatic logic [63:0] seq(input int nm, input bit wb);
    logic [63:0] t;
    t = 64'o12;
    for (int i = 0; i < nm; i++) t = {t[60:0], 3'd3};
    if (wb) t = {t[60:0], 3'd4};
    return t;
  endfunction

  logic [63:0] trace;
  int lat, nmem, nir;

  always @(negedge clk) begin
    exec_t e;
    end_t  x;
    if (reset) begin
      trace = '0; lat = 0; nmem = 0; nir = 0;
    end else begin
      trace = {trace[60:0], state};
      lat++;
      if (mem_read || mem_write) nmem++;
      if (ir_write) nir++;
      if (state == 3'd2) begin
        if (exec_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL exec_unexpected: got EXEC cycle expected none");
        end else begin
          e = exec_q.pop_front();
          chk("exec_ctrl",
              {alu_src, alu_op, reg2loc, set_flag, pc_write, pc_src, reg_write, link, retire},
              {e.alu_src, e.alu_op, e.reg2loc, e.set_flag, e.pc_write, e.pc_src,
               e.reg_write, e.link, e.retire});
        end
      end
      if (pc_write) begin
        if (end_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL end_unexpected: got pc_write expected none");
        end else begin
          x = end_q.pop_front();
          chk("state_trace", trace, x.trace);
          chk("latency", 64'(lat), 64'(x.lat));
          chk("mem_cycles", 64'(nmem), 64'(x.nmem));
          chk("ir_write_count", 64'(nir), 64'd1);
          chk("end_pc_src", 64'(pc_src), 64'(x.pc_src));
          chk("end_reg_write", 64'(reg_write), 64'(x.reg_write));
          chk("end_mem_to_reg", 64'(mem_to_reg), 64'(x.mem_to_reg));
          chk("end_retire", 64'(retire), 64'(x.retire));
          chk("end_illegal", 64'(illegal), 64'(x.illegal));
          chk("end_mem_fault", 64'(mem_fault), 64'(x.mem_fault));
          chk("end_imm", imm, x.imm);
          chk("end_retired", 64'(retired), 64'(x.ret));
        end
        trace = '0; lat = 0; nmem = 0; nir = 0;
      end
    end
  end

  // Runs one instruction from FETCH back to FETCH; rdy < 0 means mem_ready never rises.
  task automatic issue(input logic [31:0] w, input logic z, input logic n, input logic v,
                       input int rdy, input bit has_exec, input exec_t ex, input end_t en);
    bit fetched;
    int memcyc;
    fetched = 1'b0;
    memcyc = 0;
    instruction = w; zero = z; flag_n = n; flag_v = v;
    if (has_exec) exec_q.push_back(ex);
    end_q.push_back(en);
    for (int c = 0; c < 200; c++) begin
      if (state == 3'd0 && fetched) begin
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        return;
      end
      instr_valid = (state == 3'd0);
      if (state == 3'd0) fetched = 1'b1;
      if (state == 3'd3) begin
        mem_ready = (rdy >= 0) && (memcyc >= rdy);
        memcyc++;
      end else begin
        mem_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL issue_timeout: got no return to FETCH expected within 200 cycles for %h", w);
  endtask

  localparam logic [63:0] ONES = '1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected bench completion");
    $fatal(1);
  end

  initial begin
    instr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_fetch_req", 64'(fetch_req), 64'd1);
    chk("reset_ir_write", 64'(ir_write), 64'd0);
    chk("reset_imm", imm, 64'd0);
    chk("reset_retired", 64'(retired), 64'd0);
    instr_valid = 1'b0;
    reset = 1'b0;

    issue(32'h91001401, 0, 0, 0, 0, 1, mk_ex(1, 3'b010, 0, 0, 0, 2'b00, 0, 0, 0),
          mk_end(seq(0, 1), 4, 0, 2'b00, 1, 0, 1, 0, 0, 64'd5, 32'd0));
    issue(32'hAB020020, 0, 0, 0, 0, 1, mk_ex(0, 3'b010, 0, 1, 0, 2'b00, 0, 0, 0),
          mk_end(seq(0, 1), 4, 0, 2'b00, 1, 0, 1, 0, 0, 64'd0, 32'd1));
    issue(32'hEB020020, 0, 0, 0, 0, 1, mk_ex(0, 3'b011, 0, 1, 0, 2'b00, 0, 0, 0),
          mk_end(seq(0, 1), 4, 0, 2'b00, 1, 0, 1, 0, 0, 64'd0, 32'd2));
    issue(32'h5400004B, 0, 1, 0, 0, 1, mk_ex(0, 3'b000, 0, 0, 1, 2'b01, 0, 0, 1),
          mk_end(seq(0, 0), 3, 0, 2'b01, 0, 0, 1, 0, 0, 64'd2, 32'd3));
    issue(32'h5400004B, 0, 1, 1, 0, 1, mk_ex(0, 3'b000, 0, 0, 1, 2'b00, 0, 0, 1),
          mk_end(seq(0, 0), 3, 0, 2'b00, 0, 0, 1, 0, 0, 64'd2, 32'd4));
    issue(32'hB4FFFFE3, 1, 0, 0, 0, 1, mk_ex(0, 3'b000, 1, 0, 1, 2'b01, 0, 0, 1),
          mk_end(seq(0, 0), 3, 0, 2'b01, 0, 0, 1, 0, 0, ONES, 32'd5));
    issue(32'h14000003, 0, 0, 0, 0, 1, mk_ex(0, 3'b000, 0, 0, 1, 2'b01, 0, 0, 1),
          mk_end(seq(0, 0), 3, 0, 2'b01, 0, 0, 1, 0, 0, 64'd3, 32'd6));
    issue(32'h97FFFFFF, 0, 0, 0, 0, 1, mk_ex(0, 3'b000, 0, 0, 1, 2'b01, 1, 1, 1),
          mk_end(seq(0, 0), 3, 0, 2'b01, 1, 0, 1, 0, 0, ONES, 32'd7));
    issue(32'hD61F03C0, 0, 0, 0, 0, 1, mk_ex(0, 3'b000, 1, 0, 1, 2'b10, 0, 0, 1),
          mk_end(seq(0, 0), 3, 0, 2'b10, 0, 0, 1, 0, 0, 64'd0, 32'd8));
    issue(32'hF8408022, 0, 0, 0, 3, 1, mk_ex(1, 3'b010, 0, 0, 0, 2'b00, 0, 0, 0),
          mk_end(seq(4, 1), 8, 4, 2'b00, 1, 1, 1, 0, 0, 64'd8, 32'd9));
    issue(32'hF8010023, 0, 0, 0, 0, 1, mk_ex(1, 3'b010, 1, 0, 0, 2'b00, 0, 0, 0),
          mk_end(seq(1, 0), 4, 1, 2'b00, 0, 0, 1, 0, 0, 64'd16, 32'd10));
    issue(32'hF8010023, 0, 0, 0, -1, 1, mk_ex(1, 3'b010, 1, 0, 0, 2'b00, 0, 0, 0),
          mk_end(seq(16, 0), 19, 16, 2'b00, 0, 0, 0, 0, 1, 64'd16, 32'd11));
    issue(32'hF8010023, 0, 0, 0, 15, 1, mk_ex(1, 3'b010, 1, 0, 0, 2'b00, 0, 0, 0),
          mk_end(seq(16, 0), 19, 16, 2'b00, 0, 0, 1, 0, 0, 64'd16, 32'd11));
    issue(32'h00000000, 0, 0, 0, 0, 0, mk_ex(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0),
          mk_end(64'o01, 2, 0, 2'b00, 0, 0, 0, 1, 0, 64'd16, 32'd12));
    chk("retired_pre_reset", 64'(retired), 64'd12);

    // Reset in the middle of a stalled store.
    instruction = 32'hF8010023;
    exec_q.push_back(mk_ex(1, 3'b010, 1, 0, 0, 2'b00, 0, 0, 0));
    instr_valid = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_mem_state", 64'(state), 64'd3);
    chk("mid_mem_write", 64'(mem_write), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_reset_state", 64'(state), 64'd0);
    chk("post_reset_mem_write", 64'(mem_write), 64'd0);
    chk("post_reset_fetch_req", 64'(fetch_req), 64'd1);
    chk("post_reset_retired", 64'(retired), 64'd0);
    chk("post_reset_imm", imm, 64'd0);

    issue(32'h91001401, 0, 0, 0, 0, 1, mk_ex(1, 3'b010, 0, 0, 0, 2'b00, 0, 0, 0),
          mk_end(seq(0, 1), 4, 0, 2'b00, 1, 0, 1, 0, 0, 64'd5, 32'd0));
    @(posedge clk); #1;
    chk("final_retired", 64'(retired), 64'd1);
    chk("exec_q_drained", 64'(exec_q.size()), 64'd0);
    chk("end_q_drained", 64'(end_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle ARM control unit: decodes the same LEGv8 subset (B, BL, ADDI, ADDS, SUBS, B.LT, CBZ, BR, LDUR, STUR) but sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. It has a ready-handshake to instruction and data memory, a memory-timeout fault, and a registered immediate extender of parametrised width. It sits between the datapath (PC, IR, register file, ALU, flags) and the memories, and replaces the combinational decoder plus extender.

## Interface
- DATA_W, 64: datapath width; width of `imm`, minimum 32.
- MEM_TIMEOUT, 15: maximum cycles MEM waits for `mem_ready`; range 1..255.
- CNT_W, 32: width of the retired-instruction counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instruction  in  32  fetched word; sampled when `instr_valid`=1 in FETCH.
- instr_valid  in  1  instruction memory returned `instruction` this cycle.
- mem_ready  in  1  data memory completed the access this cycle.
- zero  in  1  ALU zero; used by CBZ in EXEC.
- flag_n, flag_v  in  1 each  stored N and V flags; B.LT is taken when N≠V.
- fetch_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC this cycle.
- pc_src  out  2  00 = PC+4, 01 = PC+(imm<<2), 10 = register (BR).
- reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, set_flag, link  out  1 each  datapath controls.
- alu_op  out  3  000 = pass B, 010 = add, 011 = subtract.
- imm  out  DATA_W  registered extended immediate.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  one-cycle pulse when an opcode is undecodable.
- mem_fault  out  1  one-cycle pulse when a memory access times out.
- retired  out  CNT_W  count of completed instructions; wraps at 2^CNT_W.
- state  out  3  FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.

## Operation
- Opcode matching is on the same bit fields as the single-cycle decoder. The instruction class is latched in DECODE; outputs are a function of the state and the latched class only.
- FETCH: `fetch_req`=1. On `instr_valid`: `ir_write`=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: register `imm` by format:
  - B/BL: sign-extend [25:0].
  - CB: sign-extend [23:5].
  - I: zero-extend [21:10].
  - D: sign-extend [20:12].
  - Others: 0.
- DECODE, undecodable opcode: `illegal`=1, `pc_write`=1, `pc_src`=00, then go to FETCH. No retire.
- DECODE, all other opcodes: go to EXEC.
- EXEC, ADDI/ADDS/SUBS: `alu_src`=1 for ADDI, else 0; `alu_op`=010/010/011; `set_flag`=1 for ADDS/SUBS only. Go to WB.
- EXEC, LDUR/STUR: `alu_src`=1, `alu_op`=010, `reg2loc`=1 for STUR. Go to MEM.
- EXEC, B: `pc_write`=1, `pc_src`=01.
- EXEC, BL: as B, plus `reg_write`=1 and `link`=1 (writes X30 with PC+4).
- EXEC, CBZ: `reg2loc`=1, `alu_op`=000. `pc_write`=1 with `pc_src`=01 if `zero`, else 00.
- EXEC, B.LT: `pc_write`=1 with `pc_src`=01 if `flag_n`≠`flag_v`, else 00.
- EXEC, BR: `reg2loc`=1, `pc_write`=1, `pc_src`=10.
- All EXEC branches: `retire`=1, then go to FETCH.
- MEM: hold `mem_read` (LDUR) or `mem_write` (STUR) plus the EXEC ALU controls. An 8-bit wait counter is cleared on entry and increments each cycle without `mem_ready`.
  - `mem_ready`: LDUR goes to WB. STUR asserts `pc_write`=1, `pc_src`=00, `retire`=1, then goes to FETCH.
  - Counter reaches MEM_TIMEOUT without `mem_ready`: `mem_fault`=1, `pc_write`=1, `pc_src`=00, no retire, no register write, then go to FETCH.
  - `mem_ready` in the same cycle as the timeout: `mem_ready` wins.
- WB: `reg_write`=1, `pc_write`=1, `pc_src`=00, `retire`=1. `mem_to_reg`=1 for LDUR, else 0. Then go to FETCH.
- `retired` increments on every `retire` pulse.

## Timing
- Reset (any state, including mid-MEM): next state FETCH. `imm`, `retired` and the wait counter become 0. All control outputs are 0 except `fetch_req`=1 (FETCH). Reset has priority over `instr_valid` and `mem_ready`.
- Minimum latency with `instr_valid` and `mem_ready` high on first request:
  - Branches: 3 cycles.
  - ALU instructions: 4 cycles.
  - STUR: 4 cycles.
  - LDUR: 5 cycles.
- `imm` is valid from the first EXEC cycle and holds until the next DECODE.
- `pc_write`, `reg_write`, `set_flag`, `retire`, `illegal` and `mem_fault` are high for exactly one cycle per instruction.
- No output is X in any state; don't-cares are driven as 0.

## Test plan
- ADDI X1,X0,#5 (0x91001401): state sequence 0→1→2→4→0; `imm`=5; `alu_src`=1, `alu_op`=010 in EXEC; `reg_write` and `retire` in WB; `retired`=1.
- B.LT (0x5400004B) with N=1, V=0: `imm`=2; EXEC asserts `pc_write`, `pc_src`=01. Repeat with N=V=1: `pc_src`=00.
- CBZ X3 (0xB4FFFFE3), `zero`=1: `imm` is all ones (−1); `pc_src`=01, `reg2loc`=1, `alu_op`=000.
- LDUR X2,[X1,#8] (0xF8408022), `mem_ready` after 3 wait cycles: `imm`=8; `mem_read` high for 4 MEM cycles; WB has `mem_to_reg`=1.
- STUR with `mem_ready` never asserted, MEM_TIMEOUT=15: `mem_fault` pulses after 15 cycles; no `retire`; returns to FETCH.
- Opcode 0x00000000: `illegal` pulses in DECODE. Reset asserted mid-MEM: next cycle is FETCH, `mem_write`=0, `retired`=0.
